// File: rtl/sd_read_arbiter.sv
// Round-robin arbiter and block-read sequencer sharing one sd_card controller
// between two requesters; forwards the 512-byte stream with byte indices.
`timescale 1ns/1ps
module sd_read_arbiter #(
   parameter int BLOCK_BYTES = 512,
   parameter int TIMEOUT_CYC = 50_000_000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        init_finished,
   input  logic        req0,
   input  logic        req1,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        valid0,
   output logic        valid1,
   output logic [7:0]  dout0,
   output logic [7:0]  dout1,
   output logic [8:0]  idx0,
   output logic [8:0]  idx1,
   output logic        done0,
   output logic        done1,
   output logic        err0,
   output logic        err1,
   output logic        sd_rd_req,
   output logic [31:0] sd_block_addr,
   input  logic        sd_valid,
   input  logic [7:0]  sd_dout,
   output logic [1:0]  state_dbg
);

   // Handshake: reqN is a level held until doneN; gntN spans grant..done,
   // validN/doneN/errN are single-cycle pulses, sd_rd_req is a one-cycle strobe.

   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      XFER  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t        state;
   logic          sel;
   logic          last_served;
   logic [8:0]    cnt;
   logic [TW-1:0] tout;
   logic          err_flag;
   logic          win1;

   // Requester 1 wins when alone, or when both ask and 0 was served last.
   assign win1      = req1 && (!req0 || !last_served);
   assign state_dbg = state;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         sel           <= 1'b0;
         last_served   <= 1'b1;
         cnt           <= '0;
         tout          <= '0;
         err_flag      <= 1'b0;
         gnt0          <= 1'b0;
         gnt1          <= 1'b0;
         valid0        <= 1'b0;
         valid1        <= 1'b0;
         dout0         <= '0;
         dout1         <= '0;
         idx0          <= '0;
         idx1          <= '0;
         done0         <= 1'b0;
         done1         <= 1'b0;
         err0          <= 1'b0;
         err1          <= 1'b0;
         sd_rd_req     <= 1'b0;
         sd_block_addr <= '0;
      end else begin
         valid0    <= 1'b0;
         valid1    <= 1'b0;
         done0     <= 1'b0;
         done1     <= 1'b0;
         err0      <= 1'b0;
         err1      <= 1'b0;
         sd_rd_req <= 1'b0;
         case (state)
            IDLE: begin
               // A grant still high here is the tail of a done cycle; drop it
               // first so back-to-back grants are separated by one idle cycle.
               if (gnt0 || gnt1) begin
                  gnt0 <= 1'b0;
                  gnt1 <= 1'b0;
               end else if (init_finished && (req0 || req1)) begin
                  sel           <= win1;
                  gnt0          <= !win1;
                  gnt1          <= win1;
                  sd_block_addr <= win1 ? addr1 : addr0;
                  state         <= ISSUE;
               end
            end
            ISSUE: begin
               sd_rd_req <= 1'b1;
               cnt       <= '0;
               tout      <= '0;
               err_flag  <= 1'b0;
               state     <= XFER;
            end
            XFER: begin
               if (sd_valid) begin
                  if (sel) begin
                     valid1 <= 1'b1;
                     dout1  <= sd_dout;
                     idx1   <= cnt;
                  end else begin
                     valid0 <= 1'b1;
                     dout0  <= sd_dout;
                     idx0   <= cnt;
                  end
                  cnt  <= cnt + 9'd1;
                  tout <= '0;
                  if (cnt == 9'(BLOCK_BYTES - 1)) state <= DONE;
               end else begin
                  tout <= tout + TW'(1);
                  if (tout == TW'(TIMEOUT_CYC - 1)) begin
                     err_flag <= 1'b1;
                     state    <= DONE;
                  end
               end
            end
            DONE: begin
               if (sel) begin
                  done1 <= 1'b1;
                  err1  <= err_flag;
               end else begin
                  done0 <= 1'b1;
                  err0  <= err_flag;
               end
               last_served <= sel;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/sd_read_arbiter.md
# sd_read_arbiter

Round-robin arbiter and read sequencer that shares one `sd_card` controller between two block-read requesters, such as a marker scanner and a diagnostic dumper. It grants one requester at a time and latches that requester's block address. It issues a single-cycle `rd_req`, then forwards the 512-byte stream to the granted requester with byte indices. It closes each transaction with a done or error pulse. It sits between `sd_card` (clocked from `clk` once `init_finished` is high) and the requester FSMs/SRAM writers.

## Interface
- `BLOCK_BYTES`, 512: bytes per SD block; the byte counter is 9 bits wide.
- `TIMEOUT_CYC`, 50_000_000: maximum idle cycles between sd_valid pulses in a transfer before it is aborted.
- `clk`  in  1  system clock; the only clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `init_finished`  in  1  from `sd_card`; no grants are issued while it is low.
- `req0` / `req1`  in  1  request level; held until the matching `done`.
- `addr0` / `addr1`  in  32  block address; sampled at grant.
- `gnt0` / `gnt1`  out  1  grant; high from the grant cycle through the done cycle.
- `valid0` / `valid1`  out  1  one-cycle pulse per forwarded byte.
- `dout0` / `dout1`  out  8  forwarded byte; valid only with `validN`.
- `idx0` / `idx1`  out  9  byte index 0..511 of `doutN`; equals the SRAM write address.
- `done0` / `done1`  out  1  one-cycle end-of-transaction pulse.
- `err0` / `err1`  out  1  one-cycle pulse coincident with `doneN` when the transfer timed out.
- `sd_rd_req`  out  1  to `sd_card` `rd_req`.
- `sd_block_addr`  out  32  to `sd_card` `block_addr`.
- `sd_valid`  in  1  byte strobe from `sd_card`.
- `sd_dout`  in  8  byte from `sd_card`.

## Operation
- The state machine has four states: IDLE, ISSUE, XFER, DONE.
- IDLE:
  - With `init_finished`=1 and any `reqN`=1, pick the winner and move to ISSUE.
  - The winner is the requester whose grant is being registered.
  - The winner's `addrN` is latched into `sd_block_addr`.
  - If both request, the requester not served last wins. After reset, requester 0 has priority.
- ISSUE:
  - `sd_rd_req`=1 for exactly this one cycle.
  - Clear the byte counter and timeout counter, then go to XFER.
- XFER:
  - On each `sd_valid`, register `sd_dout` to `doutN`, the counter value to `idxN`, and pulse `validN`. Then increment the counter and clear the timeout counter.
  - The byte with index 511 sends the machine to DONE.
  - With no `sd_valid`, the timeout counter increments. When it reaches `TIMEOUT_CYC`, set the error flag and go to DONE.
- DONE:
  - `doneN`=1 for one cycle, and `errN`=1 if the error flag is set.
  - Update last-served, drop the grant, and return to IDLE.
- A `reqN` still high in IDLE after its done starts a new transaction.
- Only the granted requester's `validN`/`doneN`/`errN` ever assert. The other requester's outputs stay 0.
- `sd_valid` outside XFER is ignored and is not forwarded.
- Dropping `reqN` mid-transfer does not abort the transfer. Forwarding and the done pulse still occur.
- Changes on `addrN` after grant are ignored.
- `init_finished` falling mid-transfer is not checked. The timeout covers it.

## Timing
- Reset (async, `reset_n`=0) forces all outputs to 0 and `sd_block_addr` to 0. The state goes to IDLE, the counters and error flag clear, and last-served is set so requester 0 wins next.
- Outputs leave reset on the first `clk` edge after release.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Request to grant: `reqN` high at edge k gives `gntN`=1 and a valid `sd_block_addr` after edge k+1. `sd_rd_req`=1 during the following cycle.
- Byte forwarding latency: `sd_valid` at edge t gives `validN`/`doutN`/`idxN` after edge t+1.
- `doneN` is asserted in the cycle after the 512th `validN`. `gntN` drops with the end of `doneN`.
- Minimum gap between back-to-back grants: 1 IDLE cycle.
- Timeout:
  - It counts cycles without `sd_valid`, starting at the ISSUE→XFER edge.
  - The abort fires at count == `TIMEOUT_CYC`.
  - `idxN` never wraps within a transaction, because the counter is cleared in ISSUE.

## Test plan
- Single request: `init_finished`=1, `req0`=1, `addr0`=0x2000; the model streams bytes 0x00..0xFF twice. Required: `gnt0` after 1 cycle, then one `sd_rd_req` pulse with `sd_block_addr`=0x2000. Then 512 `valid0` pulses with `idx0` 0..511 and `dout0`=idx[7:0], then one `done0`, with `err0`=0 and `gnt1` always 0.
- Simultaneous requests: `req0`=`req1`=1 held, with `addr0`=0x10 and `addr1`=0x20. Required: grant order 0,1,0,1, with `sd_block_addr` alternating 0x10 and 0x20. Each transaction gets exactly 512 valids.
- Init gating: `init_finished`=0 with `req1`=1 for 100 cycles → no grant and no `sd_rd_req`. Raising `init_finished` → `gnt1` after 1 cycle.
- Timeout with `TIMEOUT_CYC`=100: the model sends 10 bytes then stops. Required: after 10 `valid0` pulses, `done0`=`err0`=1 in the same cycle, 101 cycles after the last `sd_valid`. Then back to IDLE.
- Reset mid-XFER: assert `reset_n`=0 asynchronously at byte 200. Required: all outputs 0 immediately, without waiting for a clock edge. After release, `req1`/`req0` both high → requester 0 granted first.
- Stray strobes: `sd_valid` pulses while in IDLE → no `validN`. `addr0` changed during XFER → `sd_block_addr` unchanged.
